// File: rtl/eq_serial_word_pkg.sv
// Shared definitions for the serial word comparator: FSM encoding and slice width.
// No logic, no latency, no flow control.
package eq_serial_word_pkg;

    localparam int PAIR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/eq_serial_word_eq_slice.sv
// Combinational 2-bit equality slice; zero latency.
// No handshake: the result follows the inputs.
module eq_slice_2b
    import eq_serial_word_pkg::*;
(
    input  logic [PAIR_W-1:0] x,
    input  logic [PAIR_W-1:0] y,
    output logic              eq
);

    assign eq = (x == y);

endmodule

// File: rtl/eq_serial_word.sv
// Serial A==B comparator, two bits per clock MSB pair first; done N+1 cycles after start (N = WIDTH/2).
// start is taken only in IDLE or DONE and ignored while busy; no other backpressure.
module eq_serial_word
    import eq_serial_word_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             aeqb
);

    localparam int N_PAIRS = WIDTH / PAIR_W;
    localparam int CNT_W   = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(N_PAIRS - 1);

    if ((WIDTH < PAIR_W) || ((WIDTH % PAIR_W) != 0)) begin : g_bad_width
        $error("eq_serial_word: WIDTH must be even and >= 2");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_eq_acc;
    logic             r_aeqb;

    logic             w_eq_pair;
    logic             w_eq_next;
    logic             w_last;

    eq_slice_2b u_slice (
        .x  (r_sa[WIDTH-1 -: PAIR_W]),
        .y  (r_sb[WIDTH-1 -: PAIR_W]),
        .eq (w_eq_pair)
    );

    // The current pair is folded in combinationally so DONE entry sees the full result.
    assign w_eq_next = r_eq_acc & w_eq_pair;
    assign w_last    = (r_cnt == LAST_PAIR) || (EARLY_EXIT && !w_eq_pair);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_cnt    <= '0;
            r_eq_acc <= 1'b0;
            r_aeqb   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_eq_acc <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_COMPARE;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_COMPARE: begin
                    r_eq_acc <= w_eq_next;
                    r_sa     <= r_sa << PAIR_W;
                    r_sb     <= r_sb << PAIR_W;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_aeqb  <= w_eq_next;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_COMPARE);
    assign done = (r_state == ST_DONE);
    assign aeqb = r_aeqb;

endmodule

// File: tb/tb_eq_serial_word.sv
// Bench for eq_serial_word: three instances (W8 early-exit, W8 full-scan, W2) checked each cycle
// against a transaction-level timing model, plus directed literal expectations.
module tb_eq_serial_word;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] aeqb;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    eq_serial_word #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy[0]), .done(done[0]), .aeqb(aeqb[0]));

    eq_serial_word #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy[1]), .done(done[1]), .aeqb(aeqb[1]));

    eq_serial_word #(.WIDTH(2), .EARLY_EXIT(1'b1)) u_w2 (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a[1:0]), .b(b[1:0]),
        .busy(busy[2]), .done(done[2]), .aeqb(aeqb[2]));

    function automatic int width_of(int k);
        return (k == 2) ? 2 : 8;
    endfunction

    function automatic bit early_of(int k);
        return (k != 1);
    endfunction

    // Cycles from start to done: first mismatching pair index i gives i+2 with early exit, else N+1.
    function automatic int lat_of(int k, logic [7:0] x, logic [7:0] y);
        int w = width_of(k);
        int n = w / 2;
        for (int p = 0; p < n; p++) begin
            int sh = w - 2 - 2 * p;
            if (((x >> sh) & 8'h3) != ((y >> sh) & 8'h3))
                return early_of(k) ? p + 2 : n + 1;
        end
        return n + 1;
    endfunction

    function automatic bit eq_of(int k, logic [7:0] x, logic [7:0] y);
        logic [7:0] m = (width_of(k) == 8) ? 8'hFF : 8'h03;
        return (x & m) == (y & m);
    endfunction

    bit m_active[3];
    int m_start[3];
    int m_done[3];
    bit m_res[3];
    bit m_aeqb[3];

    always @(negedge reset_n) begin
        for (int k = 0; k < 3; k++) begin
            m_active[k] = 1'b0;
            m_aeqb[k]   = 1'b0;
        end
    end

    always @(posedge clk) begin
        bit bn;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                m_active[k] = 1'b0;
                m_aeqb[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bn = m_active[k] && (cyc > m_start[k]) && (cyc < m_done[k]);
                if (start && !bn) begin
                    m_active[k] = 1'b1;
                    m_start[k]  = cyc;
                    m_done[k]   = cyc + lat_of(k, a, b);
                    m_res[k]    = eq_of(k, a, b);
                end
                if (m_active[k] && (cyc + 1 == m_done[k]))
                    m_aeqb[k] = m_res[k];
            end
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit eb;
            bit ed;
            eb = m_active[k] && (cyc > m_start[k]) && (cyc < m_done[k]);
            ed = m_active[k] && (cyc == m_done[k]);
            chk($sformatf("model inst%0d busy", k), {31'b0, busy[k]}, {31'b0, eb});
            chk($sformatf("model inst%0d done", k), {31'b0, done[k]}, {31'b0, ed});
            chk($sformatf("model inst%0d aeqb", k), {31'b0, aeqb[k]}, {31'b0, m_aeqb[k]});
        end
    end

    int last_done[3] = '{-100, -100, -100};
    bit last_aeqb[3];
    int done_cnt[3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) begin
                last_done[k] = cyc;
                last_aeqb[k] = aeqb[k];
                done_cnt[k]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_done(input string name, input int k, input int t, input int off, input bit eq);
        chk({name, " done offset"}, 32'(last_done[k] - t), 32'(off));
        chk({name, " aeqb"}, {31'b0, last_aeqb[k]}, {31'b0, eq});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int n0;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) step();
        reset_n = 1'b1;

        // Idle after reset
        repeat (4) step();
        chk("idle busy", {31'b0, busy[0]}, 32'd0);
        chk("idle done", {31'b0, done[0]}, 32'd0);
        chk("idle aeqb", {31'b0, aeqb[0]}, 32'd0);

        // Equal operands
        t = cyc; start = 1'b1; a = 8'hA5; b = 8'hA5;
        step(); start = 1'b0;
        chk("A5 busy c1", {31'b0, busy[0]}, 32'd1);
        repeat (7) step();
        chk_done("A5 ee", 0, t, 5, 1'b1);
        chk_done("A5 full", 1, t, 5, 1'b1);
        chk_done("A5 w2", 2, t, 2, 1'b1);

        // MSB pair differs
        t = cyc; start = 1'b1; a = 8'h3C; b = 8'h7C;
        step(); start = 1'b0;
        step();
        chk("3C busy c2", {31'b0, busy[0]}, 32'd0);
        repeat (6) step();
        chk_done("3C ee", 0, t, 2, 1'b0);
        chk_done("3C full", 1, t, 5, 1'b0);
        chk_done("3C w2", 2, t, 2, 1'b1);

        // LSB pair differs, then back-to-back start held in the done cycle
        t = cyc; start = 1'b1; a = 8'hA5; b = 8'hA4;
        step(); start = 1'b0;
        repeat (4) step();
        start = 1'b1; a = 8'h00; b = 8'h00;
        step(); start = 1'b0;
        chk_done("A4 ee", 0, t, 5, 1'b0);
        chk_done("A4 full", 1, t, 5, 1'b0);
        chk_done("A4 w2", 2, t, 2, 1'b0);
        repeat (6) step();
        chk_done("b2b ee", 0, t, 10, 1'b1);
        chk_done("b2b full", 1, t, 10, 1'b1);
        chk_done("b2b w2", 2, t, 7, 1'b1);

        // Start and operand changes while comparing are ignored
        t = cyc; start = 1'b1; a = 8'hFF; b = 8'hFF;
        step(); start = 1'b0;
        step(); start = 1'b1; a = 8'h00; b = 8'h01;
        step();
        step(); start = 1'b0; a = 8'h00; b = 8'h00;
        repeat (2) step();
        chk_done("FF ee", 0, t, 5, 1'b1);
        chk_done("FF full", 1, t, 5, 1'b1);
        chk_done("FF w2 restart", 2, t, 4, 1'b0);
        repeat (4) step();

        // Reset mid-compare
        t = cyc; start = 1'b1; a = 8'hA5; b = 8'hA5;
        step(); start = 1'b0;
        repeat (2) step();
        n0 = done_cnt[0];
        reset_n = 1'b0;
        #1;
        chk("rst busy", {31'b0, busy[0]}, 32'd0);
        chk("rst done", {31'b0, done[0]}, 32'd0);
        chk("rst aeqb", {31'b0, aeqb[0]}, 32'd0);
        step(); reset_n = 1'b1;
        repeat (8) step();
        chk("rst no done", 32'(done_cnt[0]), 32'(n0));

        t = cyc; start = 1'b1; a = 8'hA5; b = 8'hA5;
        step(); start = 1'b0;
        repeat (7) step();
        chk_done("post-rst ee", 0, t, 5, 1'b1);
        chk_done("post-rst full", 1, t, 5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
